// File: rtl/calc_core.sv
// calc_core: keypad calculator with iterative division and BCD seven-segment formatting
module calc_core #(
  parameter int OPD_DIGITS = 4,
  parameter int FRAC_DIGITS = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [31:0] seg_data,
  output logic [7:0]  seg_data_en,
  output logic [7:0]  seg_dot_en,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int OW = $clog2(10 ** OPD_DIGITS);
  localparam int VW = 27;
  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_DIV = 4'd13;
  typedef enum logic [2:0] {IDLE, OPA, OPB, CALC, CONV, SHOW, ERR} state_t;
  state_t state, state_n;
  logic [OW-1:0] a, b;
  logic [3:0] op, fd, nd;
  logic [2:0] a_cnt, b_cnt;
  logic [VW-1:0] val, rem, rem_sh;
  logic [31:0] bcd;
  logic [30:0] bcd_adj;
  logic [5:0] cnt;
  logic fsub, neg, dig, opk, eqk, clr, show, dm;
  assign clr = key_valid && key_code == 4'd15;
  assign dig = key_valid && key_code < 4'd10;
  assign opk = key_valid && key_code >= K_ADD && key_code <= K_DIV;
  assign eqk = key_valid && key_code == 4'd14;
  assign rem_sh = {rem[VW-2:0], a[OW-1]};
  assign busy = state == CALC || state == CONV;
  assign err = state == ERR;
  assign show = state == OPA || (state == OPB && b_cnt != '0) || state == SHOW;
  assign dm = state == SHOW && op == K_DIV && FRAC_DIGITS > 0;
  always_ff @(posedge clk_in) state <= rst_in ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = dig ? OPA : IDLE;
      OPA: state_n = opk ? OPB : OPA;
      OPB: state_n = eqk && b_cnt != '0 ? CALC : OPB;
      CALC: state_n = op != K_DIV ? CONV : b == '0 ? ERR :
                      cnt == 6'(OW) && fd == 4'(FRAC_DIGITS) ? CONV : CALC;
      CONV: state_n = cnt == 6'(VW) ? SHOW : CONV;
      SHOW, ERR: state_n = dig ? OPA : state;
      default: state_n = IDLE;
    endcase
    if (clr) state_n = IDLE;
  end
  // top digit never reaches 5 before its final shift since results stay below 10^8
  always_comb begin
    bcd_adj = bcd[30:0];
    for (int i = 0; i < 7; i++) bcd_adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in || clr) begin
      a <= '0; b <= '0; op <= '0; a_cnt <= '0; b_cnt <= '0; val <= '0; rem <= '0;
      bcd <= '0; cnt <= '0; fd <= '0; fsub <= 1'b0; neg <= 1'b0; done <= 1'b0;
    end else begin
      done <= busy && (state_n == SHOW || state_n == ERR);
      case (state)
        IDLE, SHOW, ERR: if (dig) begin
          a <= OW'(key_code); a_cnt <= 3'd1; b <= '0; b_cnt <= '0; bcd <= {28'd0, key_code}; neg <= 1'b0;
        end
        OPA: if (dig && a_cnt < 3'(OPD_DIGITS)) begin
          a <= a * OW'(10) + OW'(key_code); a_cnt <= a_cnt + 3'd1; bcd <= {bcd[27:0], key_code};
        end else if (opk) begin
          op <= key_code; bcd <= '0;
        end
        OPB: if (dig && b_cnt < 3'(OPD_DIGITS)) begin
          b <= b * OW'(10) + OW'(key_code); b_cnt <= b_cnt + 3'd1; bcd <= {bcd[27:0], key_code};
        end else if (opk && b_cnt == '0) begin
          op <= key_code;
        end else if (eqk && b_cnt != '0) begin
          val <= '0; rem <= '0; cnt <= '0; fd <= '0; fsub <= 1'b0; neg <= 1'b0; bcd <= '0;
        end
        CALC: if (op != K_DIV) begin
          val <= op == K_ADD ? VW'(a) + VW'(b) : op == K_SUB ? (a >= b ? VW'(a - b) : VW'(b - a)) : VW'(a) * VW'(b);
          neg <= op == K_SUB && a < b;
          cnt <= '0;
        end else if (cnt != 6'(OW)) begin
          rem <= rem_sh >= VW'(b) ? rem_sh - VW'(b) : rem_sh;
          val <= {val[VW-2:0], rem_sh >= VW'(b)};
          a <= a << 1;
          cnt <= cnt + 6'd1;
        end else if (fd != 4'(FRAC_DIGITS)) begin
          if (!fsub) begin
            rem <= rem * VW'(10); val <= val * VW'(10); fsub <= 1'b1;
          end else if (rem >= VW'(b)) begin
            rem <= rem - VW'(b); val <= val + VW'(1);
          end else begin
            fsub <= 1'b0; fd <= fd + 4'd1;
          end
        end else begin
          cnt <= '0;
        end
        CONV: if (cnt != 6'(VW)) begin
          bcd <= {bcd_adj, val[VW-1]}; val <= val << 1; cnt <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    nd = 4'd1;
    for (int i = 1; i < 8; i++) if (bcd[4*i+:4] != 4'd0) nd = 4'(i + 1);
    if (dm && nd < 4'(FRAC_DIGITS + 1)) nd = 4'(FRAC_DIGITS + 1);
    seg_data = '0;
    seg_data_en = '0;
    seg_dot_en = '0;
    if (err) begin
      seg_data = 32'd14; seg_data_en = 8'd1;
    end else if (show) begin
      for (int i = 0; i < 8; i++) if (i < int'(nd)) begin
        seg_data_en[i] = 1'b1; seg_data[4*i+:4] = bcd[4*i+:4];
      end
      if (neg && nd < 4'd8) begin
        seg_data_en[nd[2:0]] = 1'b1; seg_data[{nd[2:0], 2'b00}+:4] = 4'd10;
      end
      seg_dot_en = dm ? 8'd1 << FRAC_DIGITS : 8'd0;
    end
  end
endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed key sequences checked every cycle against a decimal model of the calculator
module tb_calc_core;
  localparam int F = 3;
  logic clk_in = 1'b0, rst_in = 1'b1, key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [31:0] seg_data;
  logic [7:0] seg_data_en, seg_dot_en;
  logic busy, done, err;
  int vectors = 0, miscompares = 0;
  int ph = 0, pend = 0, busy_cyc = 0;
  bit chk = 1'b0, m_neg = 1'b0, dn;
  longint m_a = 0, m_b = 0, m_res = 0;
  int m_acnt = 0, m_bcnt = 0, m_op = 0;
  logic [31:0] es;
  logic [7:0] ee, ed;
  calc_core dut (
    .clk_in(clk_in), .rst_in(rst_in), .key_valid(key_valid), .key_code(key_code),
    .seg_data(seg_data), .seg_data_en(seg_data_en), .seg_dot_en(seg_dot_en),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk_in = ~clk_in;
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic void fmt(input longint v, input bit neg, input int fr,
                              output logic [31:0] s, output logic [7:0] en, output logic [7:0] dot);
    longint t = v;
    int nd = 1;
    s = '0; en = '0; dot = '0;
    for (longint q = v / 10; q > 0; q = q / 10) nd++;
    if (nd < fr + 1) nd = fr + 1;
    for (int i = 0; i < nd; i++) begin
      s[4*i+:4] = 4'(t % 10); en[i] = 1'b1; t = t / 10;
    end
    if (neg && v != 0) begin
      s[4*nd+:4] = 4'd10; en[nd] = 1'b1;
    end
    if (fr > 0) dot[fr] = 1'b1;
  endfunction
  function automatic void exp_out(output logic [31:0] s, output logic [7:0] en, output logic [7:0] dot);
    s = '0; en = '0; dot = '0;
    case (ph)
      1: fmt(m_a, 1'b0, 0, s, en, dot);
      2: if (m_bcnt > 0) fmt(m_b, 1'b0, 0, s, en, dot);
      4: fmt(m_res, m_neg, m_op == 13 ? F : 0, s, en, dot);
      5: begin s = 32'd14; en = 8'd1; end
      default: ;
    endcase
  endfunction
  task automatic model_key(input int k);
    if (k == 15) begin
      ph = 0; m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0; m_neg = 1'b0;
    end else if (ph == 3) begin
    end else if (k < 10) begin
      if (ph == 0 || ph == 4 || ph == 5) begin
        m_a = k; m_acnt = 1; m_b = 0; m_bcnt = 0; m_neg = 1'b0; ph = 1;
      end else if (ph == 1 && m_acnt < 4) begin
        m_a = m_a * 10 + k; m_acnt++;
      end else if (ph == 2 && m_bcnt < 4) begin
        m_b = m_b * 10 + k; m_bcnt++;
      end
    end else if (k < 14) begin
      if (ph == 1) begin m_op = k; ph = 2; end
      else if (ph == 2 && m_bcnt == 0) m_op = k;
    end else if (ph == 2 && m_bcnt > 0) begin
      ph = 3; busy_cyc = 0; m_neg = 1'b0;
      case (m_op)
        10: m_res = m_a + m_b;
        11: begin m_res = m_a >= m_b ? m_a - m_b : m_b - m_a; m_neg = m_a < m_b; end
        12: m_res = m_a * m_b;
        default: m_res = m_b == 0 ? 0 : (m_a * longint'(10 ** F)) / m_b;
      endcase
      pend = (m_op == 13 && m_b == 0) ? 5 : 4;
    end
  endtask
  always @(negedge clk_in) if (chk) begin
    dn = 1'b0;
    if (ph == 3) begin
      busy_cyc++;
      if (done === 1'b1) begin
        cmp("latency_le_128", 32'(busy_cyc <= 128), 32'd1);
        ph = pend; dn = 1'b1;
      end else begin
        cmp("busy_high", 32'(busy), 32'd1);
        cmp("busy_blank", 32'(seg_data_en), 32'd0);
        cmp("busy_err", 32'(err), 32'd0);
      end
    end
    if (ph != 3) begin
      exp_out(es, ee, ed);
      cmp("seg_data", seg_data, es);
      cmp("seg_en", 32'(seg_data_en), 32'(ee));
      cmp("seg_dot", 32'(seg_dot_en), 32'(ed));
      cmp("err", 32'(err), 32'(ph == 5));
      cmp("busy_low", 32'(busy), 32'd0);
      cmp("done", 32'(done), 32'(dn));
    end
  end
  function automatic int kc(input byte c);
    return c == "+" ? 10 : c == "-" ? 11 : c == "*" ? 12 : c == "/" ? 13 :
           c == "=" ? 14 : c == "C" ? 15 : int'(c) - 48;
  endfunction
  task automatic press(input int k);
    @(posedge clk_in); #1;
    key_valid = 1'b1; key_code = 4'(k);
    @(posedge clk_in); #1;
    key_valid = 1'b0;
    model_key(k);
  endtask
  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) press(kc(s[i]));
  endtask
  task automatic wait_done();
    for (int i = 0; i < 300 && ph == 3; i++) @(posedge clk_in);
    if (ph == 3) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: no done within 300 cycles, required a done pulse");
    end
    @(negedge clk_in); #1;
  endtask
  task automatic calc(input string s);
    keys(s);
    wait_done();
  endtask
  task automatic lit(input string n, input logic [31:0] s, input logic [7:0] en, input logic [7:0] dot);
    cmp({n, "_seg"}, seg_data, s);
    cmp({n, "_en"}, 32'(seg_data_en), 32'(en));
    cmp({n, "_dot"}, 32'(seg_dot_en), 32'(dot));
  endtask
  task automatic do_reset();
    @(posedge clk_in); #1 rst_in = 1'b1;
    @(posedge clk_in); #1;
    ph = 0; m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0; m_neg = 1'b0; m_op = 0;
    @(posedge clk_in); #1 rst_in = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0; chk = 1'b1;
    @(negedge clk_in); #1;
    lit("reset", 32'h0, 8'h00, 8'h00);
    cmp("reset_flags", {29'd0, busy, done, err}, 32'd0);
    calc("12+34567=");  lit("add_drop", 32'h00003468, 8'h0F, 8'h00);
    calc("5-12=");      lit("neg_sub", 32'h000000A7, 8'h03, 8'h00);
    calc("9999*9999="); lit("max_mul", 32'h99980001, 8'hFF, 8'h00);
    calc("22/7=");      lit("div_22_7", 32'h00003142, 8'h0F, 8'h08);
    calc("1/3=");       lit("div_1_3", 32'h00000333, 8'h0F, 8'h08);
    calc("7/0=");       lit("div0", 32'h0000000E, 8'h01, 8'h00);
    cmp("div0_err", 32'(err), 32'd1);
    keys("4"); @(negedge clk_in); #1;
    lit("after_err", 32'h4, 8'h01, 8'h00);
    cmp("after_err_flag", 32'(err), 32'd0);
    calc("+6=");        lit("after_err_sum", 32'h10, 8'h03, 8'h00);
    calc("C+=6=-=2=");  lit("ignored_keys", 32'h4, 8'h01, 8'h00);
    calc("8+*3=");      lit("op_replace", 32'h24, 8'h03, 8'h00);
    calc("5-5=");       lit("zero_sub", 32'h0, 8'h01, 8'h00);
    calc("1000-9999="); lit("neg_wide", 32'h000A8999, 8'h1F, 8'h00);
    calc("0/5=");       lit("div_zero_num", 32'h0, 8'h0F, 8'h08);
    calc("007+1=");     lit("lead_zero", 32'h8, 8'h01, 8'h00);
    keys("9/7="); keys("5");
    wait_done();        lit("busy_drop", 32'h00001285, 8'h0F, 8'h08);
    keys("22/7=");
    repeat (2) @(posedge clk_in);
    keys("C");
    repeat (150) @(posedge clk_in);
    @(negedge clk_in); #1;
    lit("clear_mid", 32'h0, 8'h00, 8'h00);
    keys("2+3");
    do_reset();
    @(negedge clk_in); #1;
    lit("reset_opb", 32'h0, 8'h00, 8'h00);
    cmp("reset_opb_flags", {29'd0, busy, done, err}, 32'd0);
    calc("2+2=");       lit("post_reset", 32'h4, 8'h01, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
